// File: rtl/roc_pkg.sv
// rtl/roc_pkg.sv - shared state, rank-direction types and default preamble address
package roc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PREFIX,
    ST_SORT,
    ST_PRE_SEND,
    ST_PRE_WAIT,
    ST_EMIT_SEND,
    ST_EMIT_WAIT,
    ST_FINISH
  } state_t;

  typedef enum logic {
    RANK_ASCENDING  = 1'b0,
    RANK_DESCENDING = 1'b1
  } rank_dir_t;

  localparam logic [9:0] DEFAULT_RST_ADDR = 10'h1FF;

endpackage

// File: rtl/roc_aer_tx.sv
// rtl/roc_aer_tx.sv - one-event AER send/wait handshake shared by preamble and emit phases
module roc_aer_tx #(
  parameter int AER_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [AER_WIDTH-1:0] addr,
  input  logic                 busy,
  output logic [AER_WIDTH-1:0] aer_addr,
  output logic                 aer_valid,
  output logic                 done
);

  logic [AER_WIDTH-1:0] addr_q;
  logic                 waiting;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      waiting <= 1'b0;
    end else if (req) begin
      addr_q  <= addr;
      waiting <= 1'b1;
    end else if (done) begin
      waiting <= 1'b0;
    end
  end

  // Strobe cycle shows the new address directly; afterwards the address is held.
  assign aer_valid = req;
  assign aer_addr  = req ? addr : addr_q;
  assign done      = waiting & ~busy;

endmodule

// File: rtl/roc_encoder_stream.sv
// rtl/roc_encoder_stream.sv - rank-order-coding encoder: stream load, counting sort, AER emission
module roc_encoder_stream
  import roc_pkg::*;
#(
  parameter int                   IMAGE_SIZE     = 256,
  parameter int                   PIXEL_BITS     = 8,
  parameter int                   AER_WIDTH      = 10,
  parameter int                   NUM_RST_EVENTS = 2,
  parameter logic [AER_WIDTH-1:0] RST_ADDR       = AER_WIDTH'(DEFAULT_RST_ADDR),
  localparam int                  IDX_BITS       = $clog2(IMAGE_SIZE),
  localparam int                  CNT_BITS       = $clog2(IMAGE_SIZE) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  DESCENDING,
  input  logic                  SKIP_ZERO,
  input  logic                  PIX_VALID,
  input  logic [PIXEL_BITS-1:0] PIX_DATA,
  output logic                  PIX_READY,
  input  logic                  AER_BUSY,
  input  logic                  ABORT,
  output logic [AER_WIDTH-1:0]  AER_ADDR,
  output logic                  AER_VALID,
  output logic                  ENCODER_RDY,
  output logic                  DONE,
  output logic [CNT_BITS-1:0]   SENT_COUNT
);

  localparam int                  NUM_VALUES = 2 ** PIXEL_BITS;
  localparam logic [CNT_BITS-1:0] N_CNT      = CNT_BITS'(IMAGE_SIZE);
  localparam logic [IDX_BITS-1:0] K_LAST     = IDX_BITS'(IMAGE_SIZE - 1);
  localparam logic [PIXEL_BITS-1:0] V_TOP    = PIXEL_BITS'(NUM_VALUES - 1);
  localparam int                  PRE_BITS   = $clog2(NUM_RST_EVENTS + 1) + 1;
  localparam logic [PRE_BITS-1:0] PRE_LAST   =
    PRE_BITS'((NUM_RST_EVENTS > 0) ? NUM_RST_EVENTS - 1 : 0);

  logic [PIXEL_BITS-1:0] pix_mem    [IMAGE_SIZE];
  logic [IDX_BITS-1:0]   sorted_mem [IMAGE_SIZE];
  logic [CNT_BITS-1:0]   hist       [NUM_VALUES];
  logic [CNT_BITS-1:0]   start_tab  [NUM_VALUES];

  state_t                state, next_state;
  rank_dir_t             dir_q;
  logic                  skip_q;
  logic [IDX_BITS-1:0]   k;
  logic [PIXEL_BITS-1:0] v;
  logic [CNT_BITS-1:0]   acc;
  logic [CNT_BITS-1:0]   p;
  logic [PRE_BITS-1:0]   pre_cnt;
  logic [CNT_BITS-1:0]   sent_q;

  logic                  beat;
  logic                  v_last;
  logic [CNT_BITS-1:0]   win_lo, win_hi, p_next;
  logic [PIXEL_BITS-1:0] sort_val;
  logic [CNT_BITS-1:0]   sort_pos;
  state_t                emit_first;
  logic                  tx_req, tx_done;
  logic [AER_WIDTH-1:0]  tx_addr;

  // Zero-valued pixels sit at one end of the rank order, so suppressing them only trims the window.
  assign win_lo     = (skip_q && dir_q == RANK_ASCENDING) ? hist[0] : '0;
  assign win_hi     = (skip_q && dir_q == RANK_DESCENDING) ? N_CNT - hist[0] : N_CNT;
  assign p_next     = p + 1'b1;
  assign emit_first = (win_lo == win_hi) ? ST_FINISH : ST_EMIT_SEND;
  assign beat       = PIX_VALID && (state == ST_LOAD);
  assign v_last     = (dir_q == RANK_DESCENDING) ? (v == '0) : (v == V_TOP);
  assign sort_val   = pix_mem[k];
  assign sort_pos   = start_tab[sort_val];
  assign SENT_COUNT = sent_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    PIX_READY   = 1'b0;
    ENCODER_RDY = 1'b0;
    DONE        = 1'b0;
    tx_req      = 1'b0;
    tx_addr     = AER_WIDTH'(sorted_mem[p[IDX_BITS-1:0]]);
    unique case (state)
      ST_IDLE: begin
        ENCODER_RDY = 1'b1;
        if (START) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        PIX_READY = 1'b1;
        if (beat && k == K_LAST) next_state = ST_PREFIX;
      end
      ST_PREFIX: begin
        if (v_last) next_state = ST_SORT;
      end
      ST_SORT: begin
        if (k == K_LAST) next_state = (NUM_RST_EVENTS > 0) ? ST_PRE_SEND : emit_first;
      end
      ST_PRE_SEND: begin
        tx_req     = 1'b1;
        tx_addr    = RST_ADDR;
        next_state = ST_PRE_WAIT;
      end
      ST_PRE_WAIT: begin
        if (tx_done) next_state = (pre_cnt == PRE_LAST) ? emit_first : ST_PRE_SEND;
      end
      ST_EMIT_SEND: begin
        tx_req     = 1'b1;
        next_state = ST_EMIT_WAIT;
      end
      ST_EMIT_WAIT: begin
        // ABORT only matters once the current event has been accepted.
        if (tx_done) next_state = (ABORT || p_next == win_hi) ? ST_FINISH : ST_EMIT_SEND;
      end
      ST_FINISH: begin
        DONE       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        pix_mem[i]    <= '0;
        sorted_mem[i] <= '0;
      end
      for (int i = 0; i < NUM_VALUES; i++) begin
        hist[i]      <= '0;
        start_tab[i] <= '0;
      end
      dir_q   <= RANK_ASCENDING;
      skip_q  <= 1'b0;
      k       <= '0;
      v       <= '0;
      acc     <= '0;
      p       <= '0;
      pre_cnt <= '0;
      sent_q  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            dir_q  <= rank_dir_t'(DESCENDING);
            skip_q <= SKIP_ZERO;
            sent_q <= '0;
            k      <= '0;
            for (int i = 0; i < NUM_VALUES; i++) hist[i] <= '0;
          end
        end
        ST_LOAD: begin
          if (beat) begin
            pix_mem[k]     <= PIX_DATA;
            hist[PIX_DATA] <= hist[PIX_DATA] + 1'b1;
            k              <= k + 1'b1;
            if (k == K_LAST) begin
              k   <= '0;
              acc <= '0;
              v   <= (dir_q == RANK_DESCENDING) ? V_TOP : '0;
            end
          end
        end
        ST_PREFIX: begin
          start_tab[v] <= acc;
          acc          <= acc + hist[v];
          v            <= (dir_q == RANK_DESCENDING) ? v - 1'b1 : v + 1'b1;
        end
        ST_SORT: begin
          // Ascending k with post-increment of the slot keeps equal values in index order.
          sorted_mem[sort_pos[IDX_BITS-1:0]] <= k;
          start_tab[sort_val]                <= sort_pos + 1'b1;
          k                                  <= k + 1'b1;
          if (k == K_LAST) begin
            k       <= '0;
            p       <= win_lo;
            pre_cnt <= '0;
          end
        end
        ST_PRE_WAIT: begin
          if (tx_done) pre_cnt <= pre_cnt + 1'b1;
        end
        ST_EMIT_SEND: begin
          sent_q <= sent_q + 1'b1;
        end
        ST_EMIT_WAIT: begin
          if (tx_done) p <= p_next;
        end
        default: ;
      endcase
    end
  end

  roc_aer_tx #(
    .AER_WIDTH(AER_WIDTH)
  ) u_aer_tx (
    .clk      (CLK),
    .rst      (RST),
    .req      (tx_req),
    .addr     (tx_addr),
    .busy     (AER_BUSY),
    .aer_addr (AER_ADDR),
    .aer_valid(AER_VALID),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_roc_encoder_stream.sv
// tb/tb_roc_encoder_stream.sv - scoreboard bench for roc_encoder_stream against a rank-order reference model
module tb_roc_encoder_stream;

  localparam int N    = 8;
  localparam int PB   = 3;
  localparam int V    = 8;
  localparam int AW   = 10;
  localparam int NRST = 2;
  localparam int CB   = 4;
  localparam int RADDR = 'h1FF;

  logic          CLK = 1'b0;
  logic          RST, START, DESCENDING, SKIP_ZERO, PIX_VALID;
  logic [PB-1:0] PIX_DATA;
  logic          PIX_READY, AER_BUSY, ABORT;
  logic [AW-1:0] AER_ADDR;
  logic          AER_VALID, ENCODER_RDY, DONE;
  logic [CB-1:0] SENT_COUNT;

  always #5 CLK = ~CLK;

  roc_encoder_stream #(
    .IMAGE_SIZE(N), .PIXEL_BITS(PB), .AER_WIDTH(AW),
    .NUM_RST_EVENTS(NRST), .RST_ADDR(10'h1FF)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .DESCENDING(DESCENDING),
    .SKIP_ZERO(SKIP_ZERO), .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA),
    .PIX_READY(PIX_READY), .AER_BUSY(AER_BUSY), .ABORT(ABORT),
    .AER_ADDR(AER_ADDR), .AER_VALID(AER_VALID), .ENCODER_RDY(ENCODER_RDY),
    .DONE(DONE), .SENT_COUNT(SENT_COUNT)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int cyc = 0;
  int busy_len = 0, abort_at = 0, start_cyc = 0, busy_left = 0;
  int strobe_cnt = 0, done_cnt = 0;
  bit chk_latency = 0;
  bit prev_valid = 0;
  logic [PB-1:0] img [N];

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // AER controller model and scoreboard consumer
  initial begin
    AER_BUSY = 1'b0;
    ABORT    = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        busy_left = 0; strobe_cnt = 0; ABORT = 1'b0; prev_valid = 0;
      end else begin
        if (busy_left > 0) busy_left--;
        if (AER_VALID) begin
          chk("strobe_spacing", int'(prev_valid), 0);
          if (strobe_cnt == 0 && chk_latency) chk("first_event_latency", cyc - start_cyc, 2 * N + V);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: got addr %0d expected no event", AER_ADDR);
          end else begin
            chk("aer_addr", int'(AER_ADDR), exp_q.pop_front());
          end
          strobe_cnt++;
          busy_left = busy_len;
          if (abort_at > 0 && strobe_cnt == NRST + abort_at) ABORT = 1'b1;
        end
        if (DONE) begin
          done_cnt++; strobe_cnt = 0; ABORT = 1'b0;
        end
        prev_valid = AER_VALID;
      end
      AER_BUSY = (busy_left > 0);
    end
  end

  task automatic start_and_feed(input bit desc, input bit skip, input int gap, input bit noise);
    int  k = 0;
    int  budget = 0;
    bit  tog = 0;
    bit  acc;
    chk("rdy_before_start", int'(ENCODER_RDY), 1);
    START = 1'b1; DESCENDING = desc; SKIP_ZERO = skip;
    @(posedge CLK); #1;
    START = 1'b0; start_cyc = cyc;
    DESCENDING = ~desc; SKIP_ZERO = ~skip;
    while (k < N && budget < 200) begin
      tog = ~tog;
      PIX_VALID = (gap == 0) || tog;
      PIX_DATA  = PIX_VALID ? img[k] : PB'($urandom);
      acc = PIX_VALID && PIX_READY;
      @(posedge CLK); #1;
      if (acc) k++;
      budget++;
    end
    if (k < N) begin
      checks++; errors++;
      $display("FAIL load_timeout: got %0d beats expected %0d", k, N);
    end
    PIX_VALID = noise;
    PIX_DATA  = PB'($urandom);
  endtask

  task automatic run_image(input bit desc, input bit skip, input int gap, input int blen,
                           input int abort_n, input bit noise);
    int seq[$];
    int base;
    int t = 0;
    for (int r = 0; r < V; r++) begin
      int val = desc ? V - 1 - r : r;
      if (skip && val == 0) continue;
      for (int i = 0; i < N; i++) if (int'(img[i]) == val) seq.push_back(i);
    end
    if (abort_n > 0 && seq.size() > abort_n) seq = seq[0:abort_n-1];
    exp_q.delete();
    for (int i = 0; i < NRST; i++) exp_q.push_back(RADDR);
    foreach (seq[i]) exp_q.push_back(seq[i]);
    busy_len = blen; abort_at = abort_n; chk_latency = (gap == 0);
    base = done_cnt;
    start_and_feed(desc, skip, gap, noise);
    if (noise) begin
      START = 1'b1; @(posedge CLK); #1; START = 1'b0;
    end
    while (done_cnt == base && t < 3000) begin
      @(posedge CLK); #1; t++;
    end
    repeat (3) @(posedge CLK);
    #1;
    PIX_VALID = 1'b0;
    chk("done_pulses", done_cnt - base, 1);
    chk("sent_count", int'(SENT_COUNT), seq.size());
    chk("events_left", exp_q.size(), 0);
    chk("rdy_after_done", int'(ENCODER_RDY), 1);
    exp_q.delete();
    abort_at = 0; chk_latency = 0;
  endtask

  task automatic set_img_a();
    int a[N] = '{3, 7, 0, 7, 1, 3, 5, 0};
    for (int i = 0; i < N; i++) img[i] = PB'(a[i]);
  endtask

  task automatic check_reset_outputs();
    chk("rst_aer_addr", int'(AER_ADDR), 0);
    chk("rst_aer_valid", int'(AER_VALID), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_sent_count", int'(SENT_COUNT), 0);
    chk("rst_pix_ready", int'(PIX_READY), 0);
    chk("rst_encoder_rdy", int'(ENCODER_RDY), 1);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; DESCENDING = 1'b0; SKIP_ZERO = 1'b0;
    PIX_VALID = 1'b0; PIX_DATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs();
    RST = 1'b0;
    @(posedge CLK); #1;

    set_img_a();
    run_image(1, 0, 0, 0, 0, 0);
    run_image(1, 1, 0, 0, 0, 0);
    run_image(0, 1, 0, 0, 0, 0);
    run_image(0, 0, 0, 0, 0, 0);
    run_image(1, 0, 1, 5, 0, 1);
    run_image(0, 1, 1, 5, 0, 1);
    run_image(1, 0, 0, 2, 3, 0);

    for (int i = 0; i < N; i++) img[i] = '0;
    run_image(1, 1, 0, 1, 0, 0);
    run_image(0, 1, 0, 0, 0, 0);
    run_image(0, 0, 0, 0, 0, 0);

    // reset while sorting, then a clean rerun of the first image
    set_img_a();
    exp_q.delete(); busy_len = 0; abort_at = 0; chk_latency = 0;
    start_and_feed(1, 0, 0, 0);
    repeat (V + 3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    check_reset_outputs();
    RST = 1'b0;
    @(posedge CLK); #1;
    run_image(1, 0, 0, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) img[i] = PB'($urandom_range(0, V - 1));
      run_image(1'($urandom), 1'($urandom), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 4)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N)) : 0,
                1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
